uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid/frame-error pulses.
// Define UART_RX_VOTE_EN to take each sample as the 3-cycle majority ending at the sample point.
module uart_rx #(
    parameter int unsigned SYS_CLOCK     = 50000000,
    parameter int unsigned UART_BAUDRATE = 115200
) (
    input  logic       i_SysClock,
    input  logic       i_ResetN,
    input  logic       i_RxSerial,
    output logic [7:0] o_RxByte,
    output logic       o_RxValid,
    output logic       o_FrameErr,
    output logic       o_RxBusy
);

    localparam int unsigned CYCLES_PER_BIT = SYS_CLOCK / UART_BAUDRATE;
    localparam int unsigned MAX_CNT        = CYCLES_PER_BIT - 1;
    localparam int unsigned HALF_CNT       = CYCLES_PER_BIT / 2 - 1;
    localparam int unsigned CNT_W          = $clog2(CYCLES_PER_BIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         sync_q, sync_d;
    logic               prev_q, prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         sr_q, sr_d;
    logic [7:0]         byte_q, byte_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               busy_q, busy_d;
    logic               rx_s;
    logic               sample_c;

    assign rx_s = sync_q[1];

`ifdef UART_RX_VOTE_EN
    // Two previous rx_s values; together with rx_s they cover the 3 cycles ending at the sample point.
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d   = {hist_q[0], rx_s};
        sample_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
    end

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) hist_q <= 2'b11;
        else           hist_q <= hist_d;
    end
`else
    assign sample_c = rx_s;
`endif

    // Next-state and output logic.
    always_comb begin
        sync_d  = {sync_q[0], i_RxSerial};
        prev_d  = rx_s;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (prev_q && !rx_s) begin
                    cnt_d   = '0;
                    state_d = START_BIT;
                end
            end
            START_BIT: begin
                if (cnt_q == CNT_W'(HALF_CNT)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sample_c ? IDLE : DATA_BITS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA_BITS: begin
                if (cnt_q == CNT_W'(MAX_CNT)) begin
                    sr_d  = {sample_c, sr_q[7:1]};
                    cnt_d = '0;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP_BIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP_BIT: begin
                // Leave mid-stop-bit so a following start edge is never missed.
                if (cnt_q == CNT_W'(MAX_CNT)) begin
                    if (sample_c) begin
                        byte_d  = sr_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign o_RxByte   = byte_q;
    assign o_RxValid  = valid_q;
    assign o_FrameErr = ferr_q;
    assign o_RxBusy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 cycles/bit; frames are built from bytes and compared with a byte-level model.
module tb_uart_rx;

    localparam int unsigned SYS_CLOCK     = 1600000;
    localparam int unsigned UART_BAUDRATE = 100000;
    localparam int CPB     = 16;
    localparam int LAT_NOM = 2 + 1 + (CPB / 2) + 9 * CPB;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int both_cnt  = 0;
    int busy_cnt  = 0;
    int last_valid_cyc = 0;
    logic [7:0] got_q[$];

    logic [7:0] model_last = 8'h00;

    uart_rx #(
        .SYS_CLOCK     (SYS_CLOCK),
        .UART_BAUDRATE (UART_BAUDRATE)
    ) dut (
        .i_SysClock (clk),
        .i_ResetN   (rst_n),
        .i_RxSerial (rx),
        .o_RxByte   (rx_byte),
        .o_RxValid  (rx_valid),
        .o_FrameErr (frame_err),
        .o_RxBusy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                valid_cnt      = valid_cnt + 1;
                last_valid_cyc = cyc;
                got_q.push_back(rx_byte);
            end
            if (frame_err) ferr_cnt = ferr_cnt + 1;
            if (rx_valid && frame_err) both_cnt = both_cnt + 1;
            if (rx_busy) busy_cnt = busy_cnt + 1;
        end
    end

    // Line level in cycle k of a 160-cycle 8N1 frame; spike inverts the sampled cycle of each data bit.
    function automatic logic frame_level(input logic [7:0] b, input logic stop, input logic spike, input int k);
        int   slot;
        logic lv;
        slot = k / CPB;
        if (slot == 0)      lv = 1'b0;
        else if (slot <= 8) lv = b[slot-1];
        else                lv = stop;
        if (spike && slot >= 1 && slot <= 8 && (k % CPB) == CPB / 2) lv = ~lv;
        return lv;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic spike, output int start_cyc);
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clk);
            if (k == 0) start_cyc = cyc;
            rx = frame_level(b, stop, spike, k);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 4;
        if (rx_byte !== 8'h00) begin n_err++; $display("FAIL reset_byte: got %h want 00", rx_byte); end
        if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_single;
        int v0, f0, st, lat;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, st);
        idle(8);
        model_last = 8'hA5;
        lat = last_valid_cyc - st;
        n_cmp += 4;
        if (valid_cnt - v0 !== 1) begin n_err++; $display("FAIL single_pulses: got %0d want 1", valid_cnt - v0); end
        if (rx_byte !== model_last) begin n_err++; $display("FAIL single_byte: got %h want %h", rx_byte, model_last); end
        if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt - f0); end
        if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1)
            begin n_err++; $display("FAIL single_latency: got %0d want %0d+-1", lat, LAT_NOM); end
    endtask

    task automatic test_back_to_back;
        int n0, st;
        n0 = got_q.size();
        send_frame(8'h00, 1'b1, 1'b0, st);
        send_frame(8'hFF, 1'b1, 1'b0, st);
        idle(8);
        model_last = 8'hFF;
        n_cmp++;
        if (got_q.size() - n0 !== 2) begin
            n_err++; $display("FAIL b2b_pulses: got %0d want 2", got_q.size() - n0);
        end else begin
            n_cmp += 2;
            if (got_q[n0] !== 8'h00) begin n_err++; $display("FAIL b2b_first: got %h want 00", got_q[n0]); end
            if (got_q[n0+1] !== 8'hFF) begin n_err++; $display("FAIL b2b_second: got %h want ff", got_q[n0+1]); end
        end
    endtask

    task automatic test_glitch;
        int v0, f0, b0, busy;
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        repeat (5) begin @(negedge clk); rx = 1'b0; end
        idle(30);
        busy = busy_cnt - b0;
        n_cmp += 4;
        if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0)
            begin n_err++; $display("FAIL glitch_pulse: got valid %0d ferr %0d want 0 0", valid_cnt - v0, ferr_cnt - f0); end
        if (busy < 1 || busy > 10) begin n_err++; $display("FAIL glitch_busy_cycles: got %0d want 1..10", busy); end
        if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_idle: got busy %b want 0", rx_busy); end
        if (rx_byte !== model_last) begin n_err++; $display("FAIL glitch_byte: got %h want %h", rx_byte, model_last); end
    endtask

    task automatic test_frame_err;
        int v0, f0, st;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, st);
        idle(6);
        n_cmp += 3;
        if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt - f0); end
        if (valid_cnt - v0 !== 0) begin n_err++; $display("FAIL ferr_valid: got %0d want 0", valid_cnt - v0); end
        if (rx_byte !== model_last) begin n_err++; $display("FAIL ferr_byte_kept: got %h want %h", rx_byte, model_last); end
        v0 = valid_cnt;
        send_frame(8'h81, 1'b1, 1'b0, st);
        idle(6);
        model_last = 8'h81;
        n_cmp += 2;
        if (valid_cnt - v0 !== 1) begin n_err++; $display("FAIL ferr_recover_pulses: got %0d want 1", valid_cnt - v0); end
        if (rx_byte !== model_last) begin n_err++; $display("FAIL ferr_recover_byte: got %h want %h", rx_byte, model_last); end
    endtask

    task automatic test_reset_mid;
        int v0, f0, st;
        v0 = valid_cnt; f0 = ferr_cnt;
        // Data bit 4 occupies cycles 80..95 of the frame.
        for (int k = 0; k < 5 * CPB + 6; k++) begin
            @(negedge clk);
            rx = frame_level(8'h55, 1'b1, 1'b0, k);
        end
        rst_n = 1'b0;
        #1;
        model_last = 8'h00;
        n_cmp += 4;
        if (rx_byte !== 8'h00) begin n_err++; $display("FAIL rstmid_byte: got %h want 00", rx_byte); end
        if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", rx_valid); end
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL rstmid_ferr: got %b want 0", frame_err); end
        if (rx_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", rx_busy); end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        send_frame(8'h12, 1'b1, 1'b0, st);
        idle(6);
        model_last = 8'h12;
        n_cmp += 3;
        if (valid_cnt - v0 !== 1) begin n_err++; $display("FAIL rstmid_pulses: got %0d want 1", valid_cnt - v0); end
        if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL rstmid_ferr_cnt: got %0d want 0", ferr_cnt - f0); end
        if (rx_byte !== model_last) begin n_err++; $display("FAIL rstmid_next_byte: got %h want %h", rx_byte, model_last); end
    endtask

    task automatic test_vote;
        int v0, st;
        logic [7:0] exp_b;
`ifdef UART_RX_VOTE_EN
        exp_b = 8'h96;
`else
        exp_b = 8'h69;
`endif
        v0 = valid_cnt;
        send_frame(8'h96, 1'b1, 1'b1, st);
        idle(6);
        model_last = exp_b;
        n_cmp += 2;
        if (valid_cnt - v0 !== 1) begin n_err++; $display("FAIL vote_pulses: got %0d want 1", valid_cnt - v0); end
        if (rx_byte !== exp_b) begin n_err++; $display("FAIL vote_byte: got %h want %h", rx_byte, exp_b); end
    endtask

    task automatic test_random;
        int v0, f0, st, gap;
        logic [7:0] b;
        logic       stop;
        for (int i = 0; i < 10; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            gap  = stop ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
            v0 = valid_cnt; f0 = ferr_cnt;
            send_frame(b, stop, 1'b0, st);
            if (stop) model_last = b;
            n_cmp += 3;
            if (valid_cnt - v0 !== (stop ? 1 : 0))
                begin n_err++; $display("FAIL rand%0d_valid: got %0d want %0d", i, valid_cnt - v0, stop ? 1 : 0); end
            if (ferr_cnt - f0 !== (stop ? 0 : 1))
                begin n_err++; $display("FAIL rand%0d_ferr: got %0d want %0d", i, ferr_cnt - f0, stop ? 0 : 1); end
            if (rx_byte !== model_last)
                begin n_err++; $display("FAIL rand%0d_byte: got %h want %h", i, rx_byte, model_last); end
            idle(gap);
        end
        idle(8);
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_reset_mid;
        test_vote;
        test_random;
        n_cmp++;
        if (both_cnt !== 0) begin n_err++; $display("FAIL valid_ferr_overlap: got %0d want 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
